// File: rtl/axil_regbank.sv
// axil_regbank: register endpoint behind the AXI-Lite-to-register bridge.
// Map: ID, CTRL, SCRATCH, COUNTER, FIFO_DATA, STATUS. Reads and okay flags are
// combinational from the address; state changes happen on the strobed clock edge.
// Optional mailbox FIFO is built only when AXIL_REGBANK_FIFO_EN is defined.
`timescale 1ns/1ps
module axil_regbank #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5247_4231
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_okay,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [STRB_WIDTH-1:0] reg_wr_strb,
  input  logic                  reg_wr_en,
  output logic                  reg_wr_okay,
  output logic                  irq
);

  // Word indices (address bits [7:2])
  localparam logic [5:0] IdxId      = 6'h00;
  localparam logic [5:0] IdxCtrl    = 6'h01;
  localparam logic [5:0] IdxScratch = 6'h02;
  localparam logic [5:0] IdxCounter = 6'h03;
  localparam logic [5:0] IdxFifo    = 6'h04;
  localparam logic [5:0] IdxStatus  = 6'h05;

  logic [5:0]            w_rd_idx;
  logic [5:0]            w_wr_idx;
  logic                  w_wr_ctrl;
  logic                  w_cnt_clr;
  logic                  w_wr_scratch;
  logic [DATA_WIDTH-1:0] w_w1c;
  logic                  w_wrap_set;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_fifo_rd_data;
  logic                  w_fifo_mapped;
  logic                  w_irq_src;
  logic                  w_unused;

  logic                  r_cnt_en;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic [DATA_WIDTH-1:0] r_counter;
  logic                  r_wrap;
  logic                  r_irq;

  assign w_rd_idx = reg_rd_addr[7:2];
  assign w_wr_idx = reg_wr_addr[7:2];
  assign w_unused = ^{reg_rd_addr[ADDR_WIDTH-1:8], reg_rd_addr[1:0],
                      reg_wr_addr[ADDR_WIDTH-1:8], reg_wr_addr[1:0]};

  // Write-side decode; CTRL (including the clear pulse) is gated by byte-0 strobe
  always_comb begin
    w_wr_ctrl    = reg_wr_en & (w_wr_idx == IdxCtrl) & reg_wr_strb[0];
    w_cnt_clr    = w_wr_ctrl & reg_wr_data[2];
    w_wr_scratch = reg_wr_en & (w_wr_idx == IdxScratch);
    w_w1c        = (reg_wr_en && (w_wr_idx == IdxStatus)) ? reg_wr_data : '0;
    w_wrap_set   = r_cnt_en & ~w_cnt_clr & (r_counter == '1);
  end

`ifdef AXIL_REGBANK_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IdxW = PtrW - 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic                  r_ovf;
  logic                  r_udf;
  logic [PtrW-1:0]       w_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_do_push;
  logic                  w_do_pop;

  // FIFO flags and push/pop qualification; a pop frees the slot a full push needs
  always_comb begin
    w_level        = r_wr_ptr - r_rd_ptr;
    w_empty        = (w_level == '0);
    w_full         = (w_level == PtrW'(FIFO_DEPTH));
    w_push         = reg_wr_en & (w_wr_idx == IdxFifo);
    w_pop          = reg_rd_en & (w_rd_idx == IdxFifo);
    w_do_pop       = w_pop & ~w_empty;
    w_do_push      = w_push & (~w_full | w_pop);
    w_fifo_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[IdxW-1:0]];
    w_fifo_mapped  = 1'b1;
    w_irq_src      = ~w_empty | r_ovf | r_udf;
    w_status       = {5'b0, r_wrap, r_udf, r_ovf, 6'b0, w_full, w_empty, 7'b0, 9'(w_level)};
  end

  // Mailbox storage; contents are discarded by resetting the pointers
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[IdxW-1:0]] <= reg_wr_data;
  end

  // FIFO pointers and sticky overflow/underflow flags (set beats W1C)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_ovf <= (r_ovf & ~w_w1c[24]) | (w_push & w_full & ~w_pop);
      r_udf <= (r_udf & ~w_w1c[25]) | (w_pop & w_empty);
    end
  end
`else
  logic w_unused_fifo;

  // No mailbox: 0x10 unmapped, STATUS shows a permanently empty FIFO
  always_comb begin
    w_fifo_rd_data = '0;
    w_fifo_mapped  = 1'b0;
    w_irq_src      = r_wrap;
    w_status       = {5'b0, r_wrap, 9'b0, 1'b1, 16'b0};
  end

  assign w_unused_fifo = reg_rd_en;
`endif

  // Control register: CNT_EN and IRQ_EN; CNT_CLR is a pulse, not stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_en <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_cnt_en <= reg_wr_data[0];
      r_irq_en <= reg_wr_data[1];
    end
  end

  // Scratch register with per-byte strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scratch <= 32'hDEAD_BEEF;
    end else if (w_wr_scratch) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (reg_wr_strb[i]) r_scratch[8*i +: 8] <= reg_wr_data[8*i +: 8];
      end
    end
  end

  // Cycle counter: clear beats increment; wrap flag is sticky (set beats W1C)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
      r_wrap    <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_counter <= '0;
      else if (r_cnt_en) r_counter <= r_counter + 32'd1;
      r_wrap <= (r_wrap & ~w_w1c[26]) | w_wrap_set;
    end
  end

  // Level interrupt, registered from current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_irq_en & w_irq_src;
  end

  assign irq = r_irq;

  // Combinational read mux
  always_comb begin
    reg_rd_data = '0;
    reg_rd_okay = 1'b1;
    case (w_rd_idx)
      IdxId:      reg_rd_data = ID_VALUE;
      IdxCtrl:    reg_rd_data = {30'b0, r_irq_en, r_cnt_en};
      IdxScratch: reg_rd_data = r_scratch;
      IdxCounter: reg_rd_data = r_counter;
      IdxFifo: begin
        reg_rd_data = w_fifo_rd_data;
        reg_rd_okay = w_fifo_mapped;
      end
      IdxStatus:  reg_rd_data = w_status;
      default:    reg_rd_okay = 1'b0;
    endcase
  end

  // Combinational write acknowledge
  always_comb begin
    case (w_wr_idx)
      IdxId, IdxCtrl, IdxScratch, IdxCounter, IdxStatus: reg_wr_okay = 1'b1;
      IdxFifo: reg_wr_okay = w_fifo_mapped;
      default: reg_wr_okay = 1'b0;
    endcase
  end

endmodule
